bank_rr_sched: RTL
==================

// Module: bank_rr_sched
// PURPOSE
//  Controller for the 4 x 4-bit register bank (q0..q3, load0..load3, 4:1 select mux).
//  - Write side: round-robin arbiter. Four requesters share the bank's single write path.
//    Each requester presents 4-bit data and a 2-bit target address. At most one register
//    is loaded per cycle.
//  - Read side: scan sequencer. Steps the mux select through 0..3 at a programmable rate
//    for display/serial readout.
//  - Sits between the requesting blocks and the bank datapath. Drives only load and select
//    controls plus write data.
// PARAMETERS
//  SCAN_DIV  4  ck cycles per scan step, legal range 1..255.
//  DW        4  data width of one bank register.
// PORTS
//  ck           in   1      clock, all state updates on rising edge
//  res          in   1      synchronous reset, active-high
//  req          in   4      req[i]=1: requester i wants a write
//  wdata        in   4*DW   requester i data on wdata[i*DW +: DW]
//  waddr        in   8      requester i target register on waddr[2*i +: 2]
//  gnt          out  4      one-hot grant pulse, 1 cycle
//  load         out  4      one-hot bank load enables, load[k] loads q_k
//  wd           out  DW     write data to bank, valid while |load
//  scan_en      in   1      1: scan sequencer advances
//  sel          out  2      bank mux select
//  scan_strobe  out  1      1-cycle pulse in the cycle sel takes a new value
// BEHAVIOUR
//  Reset (res=1 at edge): outputs and state are cleared.
//  - gnt=0, load=0, wd=0, sel=0, scan_strobe=0.
//  - Priority pointer ptr=0, divider count div=0.
//  - Reset overrides everything. A pending request is dropped; a scan step in progress restarts.
//  Arbitration: winner chosen from req sampled at edge N.
//  - Search starts at index ptr and runs ptr, ptr+1, ... mod 4.
//  - First eligible requester wins.
//  - Eligible means req[i]=1 and gnt[i]=0 in cycle N. The requester being granted is masked
//    for that one cycle, so a held req is never double-granted.
//  Latency: 1 cycle, all outputs registered.
//  - For winner w at edge N, during cycle N+1:
//    - gnt[w]=1
//    - load[waddr_w]=1
//    - wd=wdata_w, as sampled at edge N
//  - ptr <= (w+1) mod 4 on the same edge.
//  - No eligible requester: gnt=0, load=0, wd holds its last value, ptr unchanged.
//  Handshake rules.
//  - Requester holds req, wdata and waddr stable until it sees gnt.
//  - req still 1 in the cycle after gnt counts as a new request.
//  - req dropped before gnt is allowed; the request is withdrawn with no error.
//  - Two requesters targeting the same address are serialized; the later write wins in the bank.
//  - Fairness: with all four requesting continuously, each is granted exactly once in every
//    4 consecutive grant slots.
//  Scan sequencer.
//  - scan_en=1: div counts 0..SCAN_DIV-1. On the edge where div==SCAN_DIV-1:
//    - div <= 0
//    - sel <= sel+1 (wraps 3->0)
//    - scan_strobe=1 for the following cycle
//  - scan_en=0: div and sel hold, scan_strobe=0. Re-enabling resumes from the held div.
//  - SCAN_DIV=1: sel advances every cycle and scan_strobe stays high.
//  Simultaneous events.
//  - Write and scan are independent; no stall.
//  - A load to the register currently selected is legal. The mux output reflects the new value
//    from the cycle after load.
// TESTING
//  1. Reset: res=1 two cycles, req=4'hF -> gnt=0, load=0, sel=0, scan_strobe=0 throughout;
//     first grant after release goes to requester 0.
//  2. Single request: req=4'b0100, waddr[5:4]=2'd3, wdata[11:8]=4'hA at edge N
//     -> cycle N+1 gnt=4'b0100, load=4'b1000, wd=4'hA. Drop req, then gnt=0.
//  3. All four held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3, no idle cycles,
//     never the same index twice in a row.
//  4. Fairness: after a grant to 2, req=4'b0101 held -> grants 0,2,0,2; ptr wraps correctly.
//  5. Scan: SCAN_DIV=4, scan_en=1 for 20 cycles -> sel steps 0,1,2,3,0 every 4 cycles,
//     one scan_strobe per step. scan_en=0 mid-step -> sel frozen; re-enable resumes remaining count.
//  6. Reset mid-operation: res pulsed while req=4'hF, sel=2, div=2 -> next cycle gnt=0, sel=0,
//     ptr=0. Arbitration and scan restart as in test 1.

Source files
------------

// File: rtl/bank_rr_sched.sv
// bank_rr_sched: round-robin write arbiter and scan sequencer for a 4 x DW register bank
module bank_rr_sched #(
    parameter int SCAN_DIV = 4,
    parameter int DW       = 4
) (
    input  logic          ck,
    input  logic          res,
    input  logic [3:0]    req,
    input  logic [4*DW-1:0] wdata,
    input  logic [7:0]    waddr,
    output logic [3:0]    gnt,
    output logic [3:0]    load,
    output logic [DW-1:0] wd,
    input  logic          scan_en,
    output logic [1:0]    sel,
    output logic          scan_strobe
);
    localparam logic [7:0] DIV_MAX = 8'(SCAN_DIV - 1);
    logic [1:0] ptr;
    logic [1:0] w;
    logic [1:0] idx;
    logic [3:0] elig;
    logic       found;
    logic [7:0] div;
    // a requester granted this cycle is masked so a held req is not granted twice
    always_comb begin
        elig  = req & ~gnt;
        found = 1'b0;
        w     = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
    end
    always_ff @(posedge ck) begin
        if (res) begin
            gnt         <= '0;
            load        <= '0;
            wd          <= '0;
            ptr         <= '0;
            sel         <= '0;
            div         <= '0;
            scan_strobe <= 1'b0;
        end else begin
            gnt         <= found ? 4'b0001 << w : 4'b0000;
            load        <= found ? 4'b0001 << waddr[2*w +: 2] : 4'b0000;
            wd          <= found ? wdata[w*DW +: DW] : wd;
            ptr         <= found ? w + 2'd1 : ptr;
            div         <= !scan_en ? div : (div == DIV_MAX) ? 8'd0 : div + 8'd1;
            sel         <= (scan_en && div == DIV_MAX) ? sel + 2'd1 : sel;
            scan_strobe <= scan_en && div == DIV_MAX;
        end
    end
endmodule
